counter_slot_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4-bit up-counting timer among several requesters. Each requester asks for a timed slot of a programmed length. The block grants the shared counter to one requester at a time, counts from 0 up to that requester's terminal count, then pulses a per-requester done. It sits between the counter datapath and the client blocks that need short cycle-accurate delays, and replaces per-client private counters.

---
 rtl/counter_slot_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter: round-robin owner selection for one shared up-counter;
// each granted requester runs 0..tc, then receives a one-cycle done pulse.
module counter_slot_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [OW-1:0]    owner, rr, winner, owner_d, rr_d;
    logic [WIDTH-1:0] tc, tc_d, count_d;
    logic [NREQ-1:0]  grant_d, done_d;
    logic             busy_d, any_req, abort, at_tc;

    assign any_req = |req;
    assign abort   = !req[owner];
    assign at_tc   = count == tc;

    // Scan downward so the nearest requester after rr is the last one written.
    always_comb begin
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[OW'((int'(rr) + k) % NREQ)]) winner = OW'((int'(rr) + k) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            rr    <= OW'(NREQ - 1);
            tc    <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            state <= next_state;
            owner <= owner_d;
            rr    <= rr_d;
            tc    <= tc_d;
            grant <= grant_d;
            done  <= done_d;
            busy  <= busy_d;
            count <= count_d;
        end
    end

    // A dropped owner request wins over reaching the terminal count.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = any_req ? RUN : IDLE;
            RUN:     next_state = abort ? IDLE : at_tc ? DONE : RUN;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        owner_d = owner;
        rr_d    = rr;
        tc_d    = tc;
        grant_d = '0;
        done_d  = '0;
        count_d = '0;
        busy_d  = next_state != IDLE;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    tc_d    = len[winner*WIDTH +: WIDTH];
                    grant_d = NREQ'(1) << winner;
                end
            end
            RUN: begin
                if (abort) begin
                    rr_d = owner;
                end else if (at_tc) begin
                    done_d  = NREQ'(1) << owner;
                    count_d = count;
                end else begin
                    grant_d = NREQ'(1) << owner;
                    count_d = count + 1'b1;
                end
            end
            default: rr_d = owner;
        endcase
    end
endmodule
